// File: rtl/controle_tentativa.sv
// controle_tentativa
//   Input stage of the safe. Captures the 4-bit attempt from the switches on a
//   debounced confirm-button press, then holds it on `tentativa` for the
//   combinational subtractor/comparator. It consumes the comparator result,
//   counts consecutive failures and enforces a timed lockout.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   chaves     in   [3:0] raw attempt switches, sampled only on an accepted press
//   confirmar  in   raw pushbutton (active-high, asynchronous, may bounce)
//   senha_ok   in   comparator result for the current tentativa (1 = match)
//   tentativa  out  [3:0] registered attempt value
//   valido     out  one-cycle pulse while senha_ok is being evaluated
//   aberto     out  safe open (latched until the next accepted press)
//   bloqueado  out  lockout active
//   erros      out  [1:0] current consecutive-failure count
module controle_tentativa #(
  parameter int DEB_CYCLES  = 4,
  parameter int MAX_ERROS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] chaves,
  input  logic       confirmar,
  input  logic       senha_ok,
  output logic [3:0] tentativa,
  output logic       valido,
  output logic       aberto,
  output logic       bloqueado,
  output logic [1:0] erros
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    MAX_E     = 2'(MAX_ERROS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] AVALIA = 2'd1;
  localparam logic [1:0] BLOQ   = 2'd2;

  // ---------------------------------------------------------------------------
  // Synchronizer + debouncer + press detector
  // ---------------------------------------------------------------------------
  logic          sync1_reg;
  logic          sync2_reg;
  logic          deb_level_reg;
  logic          armed_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          press_reg;

  // After reset the debouncer is "unarmed": it first has to see DEB_CYCLES
  // consecutive low samples before any rise is trusted. This is what keeps a
  // button that is held through reset release from producing a press; the
  // user must let go and press again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      deb_level_reg <= 1'b0;
      armed_reg     <= 1'b0;
      deb_cnt_reg   <= '0;
      press_reg     <= 1'b0;
    end else begin
      sync1_reg <= confirmar;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (!armed_reg) begin
        if (sync2_reg) begin
          deb_cnt_reg <= '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          armed_reg   <= 1'b1;
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end else if (sync2_reg == deb_level_reg) begin
        // Any return to the current level restarts the stability count.
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        deb_level_reg <= sync2_reg;
        deb_cnt_reg   <= '0;
        // Only a 0->1 change of the debounced level is a press.
        press_reg     <= sync2_reg;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Attempt / evaluation / lockout FSM
  // ---------------------------------------------------------------------------
  logic [1:0]    state_reg;
  logic [3:0]    tentativa_reg;
  logic          valido_reg;
  logic          aberto_reg;
  logic          bloqueado_reg;
  logic [1:0]    erros_reg;
  logic [LW-1:0] lock_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tentativa_reg <= 4'd0;
      valido_reg    <= 1'b0;
      aberto_reg    <= 1'b0;
      bloqueado_reg <= 1'b0;
      erros_reg     <= 2'd0;
      lock_cnt_reg  <= '0;
    end else begin
      valido_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Presses arriving in AVALIA or BLOQ are simply never looked at.
          if (press_reg) begin
            tentativa_reg <= chaves;
            aberto_reg    <= 1'b0;
            valido_reg    <= 1'b1;
            state_reg     <= AVALIA;
          end
        end
        AVALIA: begin
          // senha_ok is a combinational function of tentativa_reg, which was
          // loaded on the previous edge, so it is settled by now.
          if (senha_ok) begin
            aberto_reg <= 1'b1;
            erros_reg  <= 2'd0;
            state_reg  <= IDLE;
          end else if (erros_reg + 2'd1 == MAX_E) begin
            erros_reg     <= MAX_E;
            bloqueado_reg <= 1'b1;
            lock_cnt_reg  <= LOCK_LAST;
            state_reg     <= BLOQ;
          end else begin
            erros_reg <= erros_reg + 2'd1;
            state_reg <= IDLE;
          end
        end
        BLOQ: begin
          // Loaded with LOCK_CYCLES-1 and left on the cycle it reads 0, so
          // bloqueado is high for exactly LOCK_CYCLES cycles.
          if (lock_cnt_reg == '0) begin
            bloqueado_reg <= 1'b0;
            erros_reg     <= 2'd0;
            state_reg     <= IDLE;
          end else begin
            lock_cnt_reg <= lock_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tentativa = tentativa_reg;
  assign valido    = valido_reg;
  assign aberto    = aberto_reg;
  assign bloqueado = bloqueado_reg;
  assign erros     = erros_reg;

endmodule

// File: tb/tb_controle_tentativa.sv
// Testbench for controle_tentativa: directed scenarios followed by randomized
// button/switch/reset activity, all checked every cycle against a behavioural
// model of the safe's input stage.
module tb_controle_tentativa;

  localparam int DEB  = 4;
  localparam int MAXE = 3;
  localparam int LOCK = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] chaves;
  logic       confirmar;
  logic       senha_ok;
  logic [3:0] tentativa;
  logic       valido;
  logic       aberto;
  logic       bloqueado;
  logic [1:0] erros;

  always #5 clk = ~clk;

  controle_tentativa #(
    .DEB_CYCLES (DEB),
    .MAX_ERROS  (MAXE),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .chaves   (chaves),
    .confirmar(confirmar),
    .senha_ok (senha_ok),
    .tentativa(tentativa),
    .valido   (valido),
    .aberto   (aberto),
    .bloqueado(bloqueado),
    .erros    (erros)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  bit         m_s1, m_s2;      // two-stage synchronizer delay of the raw button
  bit         seen_q[$];       // last DEB synchronized samples seen
  bit         m_armed, m_level, m_pulse;
  logic [3:0] m_tent;
  bit         m_valido, m_aberto, m_bloq;
  int         m_erros, m_phase, m_lock_left;
  logic [3:0] secret;
  int         valid_seen, bloq_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; seen_q.delete();
    m_armed = 0; m_level = 0; m_pulse = 0;
    m_tent = 4'd0; m_valido = 0; m_aberto = 0; m_bloq = 0;
    m_erros = 0; m_phase = 0; m_lock_left = 0;
  endtask

  // One rising edge of the model, using the inputs as they stand at the edge.
  task automatic model_step();
    bit p, seen, all0, alld;
    p = m_pulse;
    case (m_phase)
      0: if (p) begin
           m_tent = chaves; m_aberto = 0; m_valido = 1; m_phase = 1;
         end
      1: begin
           m_valido = 0;
           if (senha_ok) begin
             m_aberto = 1; m_erros = 0; m_phase = 0;
           end else if (m_erros + 1 < MAXE) begin
             m_erros++; m_phase = 0;
           end else begin
             m_erros = MAXE; m_bloq = 1; m_lock_left = LOCK; m_phase = 2;
           end
         end
      default: begin
           m_lock_left--;
           if (m_lock_left == 0) begin
             m_bloq = 0; m_erros = 0; m_phase = 0;
           end
         end
    endcase
    // button: the level changes once the last DEB synchronized samples all
    // disagree with it; nothing is trusted until DEB lows have been seen
    seen = m_s2; m_s2 = m_s1; m_s1 = confirmar;
    seen_q.push_back(seen);
    if (seen_q.size() > DEB) void'(seen_q.pop_front());
    m_pulse = 0;
    if (seen_q.size() == DEB) begin
      all0 = 1; alld = 1;
      foreach (seen_q[i]) begin
        if (seen_q[i]) all0 = 0;
        if (seen_q[i] == m_level) alld = 0;
      end
      if (!m_armed) begin
        if (all0) m_armed = 1;
      end else if (alld) begin
        m_level = ~m_level;
        m_pulse = m_level;
      end
    end
  endtask

  task automatic compare();
    chk("tentativa", 32'(tentativa), 32'(m_tent));
    chk("valido",    32'(valido),    32'(m_valido));
    chk("aberto",    32'(aberto),    32'(m_aberto));
    chk("bloqueado", 32'(bloqueado), 32'(m_bloq));
    chk("erros",     32'(erros),     32'(m_erros));
  endtask

  // Called at a negedge; returns at the next negedge after checking.
  task automatic run_cycle();
    senha_ok = (m_tent == secret);   // the downstream comparator
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare();
    if (valido) valid_seen++;
    if (bloqueado) bloq_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle();
  endtask

  task automatic press(input logic [3:0] chv, input int hold, input int gap);
    chaves = chv; confirmar = 1'b1;
    idle(hold);
    confirmar = 1'b0;
    idle(gap);
  endtask

  // Called at a negedge: asynchronous reset away from any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tentativa", 32'(tentativa), 32'd0);
    chk("rst_valido",    32'(valido),    32'd0);
    chk("rst_aberto",    32'(aberto),    32'd0);
    chk("rst_bloqueado", 32'(bloqueado), 32'd0);
    chk("rst_erros",     32'(erros),     32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] wrong_key();
    logic [3:0] k;
    k = secret ^ 4'(1 + $urandom_range(0, 14));
    return k;
  endfunction

  initial begin
    int lat;
    logic [3:0] held;
    bit seen_load;
    rst_n = 1'b1; confirmar = 1'b0; chaves = 4'd0; senha_ok = 1'b0;
    secret = 4'hA; valid_seen = 0; bloq_seen = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    idle(10);

    // clean press, correct key: load latency and opening
    chaves = 4'hA; confirmar = 1'b1; lat = 0;
    for (int k = 1; k <= 30; k++) begin
      run_cycle();
      if (valido && lat == 0) lat = k;
    end
    chk("press_latency", 32'(lat), 32'(DEB + 3));
    chk("open_tentativa", 32'(tentativa), 32'hA);
    chk("open_aberto", 32'(aberto), 32'd1);
    confirmar = 1'b0; idle(12);

    // bouncing press then long hold: one evaluation only
    valid_seen = 0; chaves = 4'h3;
    for (int i = 0; i < 5; i++) begin
      confirmar = (i % 2 == 0); idle(2);
    end
    confirmar = 1'b1; idle(20);
    chk("bounce_pulses", 32'(valid_seen), 32'd1);
    confirmar = 1'b0; idle(12);

    // clear the failure count, then three wrong attempts -> lockout
    press(4'hA, 10, 8);
    chk("erros_cleared", 32'(erros), 32'd0);
    press(wrong_key(), 10, 8);
    chk("erros_1", 32'(erros), 32'd1);
    press(wrong_key(), 10, 8);
    chk("erros_2", 32'(erros), 32'd2);
    bloq_seen = 0;
    press(wrong_key(), 10, 0);
    chk("lock_active", 32'(bloqueado), 32'd1);
    chk("lock_erros", 32'(erros), 32'd3);
    held = m_tent; valid_seen = 0;
    press(4'h5, 7, 3);
    chk("lock_no_valido", 32'(valid_seen), 32'd0);
    chk("lock_tent_hold", 32'(tentativa), 32'(held));
    idle(12);
    chk("lock_len", 32'(bloq_seen), 32'(LOCK));
    chk("lock_exit_erros", 32'(erros), 32'd0);

    // two wrong then a correct one, no lockout
    bloq_seen = 0;
    press(wrong_key(), 10, 8);
    press(wrong_key(), 10, 8);
    chk("two_wrong_erros", 32'(erros), 32'd2);
    press(4'hA, 10, 8);
    chk("recover_erros", 32'(erros), 32'd0);
    chk("recover_aberto", 32'(aberto), 32'd1);
    chk("recover_no_lock", 32'(bloq_seen), 32'd0);

    // open, then a wrong attempt closes on its load edge
    chaves = wrong_key(); confirmar = 1'b1; seen_load = 0;
    for (int k = 0; k < 30; k++) begin
      run_cycle();
      if (valido && !seen_load) begin
        seen_load = 1;
        chk("close_on_load", 32'(aberto), 32'd0);
      end
    end
    chk("close_load_seen", 32'(seen_load), 32'd1);
    chk("close_erros", 32'(erros), 32'd1);
    confirmar = 1'b0; idle(10);

    // reset mid-lockout with the button held
    press(wrong_key(), 10, 8);
    press(wrong_key(), 10, 0);
    confirmar = 1'b1; idle(3);
    chk("pre_reset_lock", 32'(bloqueado), 32'd1);
    do_reset();
    valid_seen = 0;
    idle(30);
    chk("no_press_after_reset", 32'(valid_seen), 32'd0);
    confirmar = 1'b0; idle(10);
    press(4'hA, 10, 8);
    chk("press_after_release", 32'(valid_seen), 32'd1);

    // randomized activity
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) confirmar = ~confirmar;
      chaves = ($urandom_range(0, 2) == 0) ? secret : 4'($urandom);
      if (c % 300 == 299) secret = 4'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      else run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
